// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU operation sequencer: opcodes, FSM encoding,
// and the opcode legality helper.
package alu_seq_pkg;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_OR  = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_SUB = 3'd3;
  localparam logic [2:0] OP_SLT = 3'd4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    RESP   = 2'd2
  } seq_state_t;

  // Opcodes 5..7 have no ALU function and are answered with an error response.
  function automatic logic is_legal_op(input logic [2:0] op);
    return (op <= OP_SLT);
  endfunction

endpackage

// File: rtl/alu_ref_model.sv
// Combinational expected result for the ALU, used to cross-check the
// captured gate-level result when RESULT_CHECK_EN is defined.
module alu_ref_model
  import alu_seq_pkg::*;
(
  input  logic [31:0] x,
  input  logic [31:0] y,
  input  logic [2:0]  opcode,
  output logic [31:0] f,
  output logic        zero
);

  logic [31:0] diff;

  // Plain arithmetic view of each ALU function; SLT uses the raw sign of x-y.
  always_comb begin
    diff = x - y;
    f    = '0;
    case (opcode)
      OP_ADD:  f = x + y;
      OP_OR:   f = x | y;
      OP_AND:  f = x & y;
      OP_SUB:  f = diff;
      OP_SLT:  f = {31'b0, diff[31]};
      default: f = '0;
    endcase
    zero = (f == 32'd0);
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Command-side initiator for the combinational ALU: accepts an op, holds the
// ALU inputs for SETTLE_CYCLES edges, captures the result and returns it.
// Optional build macro: RESULT_CHECK_EN adds rsp_mismatch and a reference model.
//
// state  | meaning
// IDLE   | ready for a command
// SETTLE | ALU inputs held while the gate-level ALU propagates
// RESP   | response presented, waiting for rsp_ready
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4,
  parameter int OPCNT_W       = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [31:0]        cmd_x,
  input  logic [31:0]        cmd_y,
  input  logic [2:0]         cmd_opcode,
  output logic [31:0]        alu_x,
  output logic [31:0]        alu_y,
  output logic [2:0]         alu_opcode,
  input  logic [31:0]        alu_f,
  input  logic               alu_overflow,
  input  logic               alu_cout,
  input  logic               alu_zero,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [31:0]        rsp_f,
  output logic               rsp_overflow,
  output logic               rsp_cout,
  output logic               rsp_zero,
  output logic               rsp_err,
`ifdef RESULT_CHECK_EN
  output logic               rsp_mismatch,
`endif
  output logic [OPCNT_W-1:0] op_count
);

  localparam logic [7:0] CNT_INIT = 8'(SETTLE_CYCLES - 1);

  seq_state_t state, state_nxt;
  logic [7:0] cnt;
  logic       accept, reject, capture, handshake;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state and the per-cycle action strobes.
  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    accept    = 1'b0;
    reject    = 1'b0;
    capture   = 1'b0;
    handshake = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          if (is_legal_op(cmd_opcode)) begin
            accept    = 1'b1;
            state_nxt = SETTLE;
          end else begin
            reject    = 1'b1;
            state_nxt = RESP;
          end
        end
      end
      SETTLE: begin
        if (cnt == 8'd0) begin
          capture   = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          handshake = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Settle timer, ALU operand registers, response registers and op counter.
  // ALU operands are only loaded by legal commands and never cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt          <= '0;
      alu_x        <= '0;
      alu_y        <= '0;
      alu_opcode   <= '0;
      rsp_valid    <= 1'b0;
      rsp_f        <= '0;
      rsp_overflow <= 1'b0;
      rsp_cout     <= 1'b0;
      rsp_zero     <= 1'b0;
      rsp_err      <= 1'b0;
      op_count     <= '0;
    end else begin
      if (accept) begin
        alu_x      <= cmd_x;
        alu_y      <= cmd_y;
        alu_opcode <= cmd_opcode;
        cnt        <= CNT_INIT;
      end else if (state == SETTLE && cnt != 8'd0) begin
        cnt <= cnt - 8'd1;
      end
      if (reject) begin
        rsp_f        <= '0;
        rsp_overflow <= 1'b0;
        rsp_cout     <= 1'b0;
        rsp_zero     <= 1'b0;
        rsp_err      <= 1'b1;
        rsp_valid    <= 1'b1;
      end
      if (capture) begin
        rsp_f        <= alu_f;
        rsp_overflow <= alu_overflow;
        rsp_cout     <= alu_cout;
        rsp_zero     <= alu_zero;
        rsp_err      <= 1'b0;
        rsp_valid    <= 1'b1;
      end
      if (handshake) begin
        rsp_valid <= 1'b0;
        op_count  <= op_count + OPCNT_W'(1);
      end
    end
  end

`ifdef RESULT_CHECK_EN
  logic [31:0] ref_f;
  logic        ref_zero;

  alu_ref_model u_ref (
    .x      (alu_x),
    .y      (alu_y),
    .opcode (alu_opcode),
    .f      (ref_f),
    .zero   (ref_zero)
  );

  // Mismatch flag travels with the captured response; illegal ops report 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       rsp_mismatch <= 1'b0;
    else if (reject)  rsp_mismatch <= 1'b0;
    else if (capture) rsp_mismatch <= (alu_f != ref_f) || (alu_zero != ref_zero);
  end
`endif

endmodule
